// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for pipe_skid_stage: upstream valid/ready/data, downstream
// valid/ready/data, squash request and occupancy report.
interface pipe_skid_stage_if #(
  parameter int unsigned WIDTH = 160
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occ;

  // Producer/consumer side (drives inputs, observes the stage)
  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occ
  );

  // The stage itself
  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occ
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage (HEAD + SKID) with registered in_ready,
// registered out_data, BUBBLE fill on empty entries and selectable flush depth.
module pipe_skid_stage #(
  parameter int unsigned      WIDTH           = 160,
  parameter logic [WIDTH-1:0] BUBBLE          = {WIDTH{1'b0}},
  parameter bit               FLUSH_KEEP_SKID = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  pipe_skid_stage_if.slave   bus
);

  // Encodings equal the entry count so occ is the state register itself
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] head, head_n;
  logic [WIDTH-1:0] skid, skid_n;
  logic             rdy;
  logic             out_valid;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid     = (state != EMPTY);
  assign in_xfer       = bus.in_valid & rdy;
  assign out_xfer      = out_valid & bus.out_ready;

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head;
  assign bus.occ       = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      head  <= BUBBLE;
      skid  <= BUBBLE;
      rdy   <= 1'b1;
    end else begin
      state <= state_n;
      head  <= head_n;
      skid  <= skid_n;
      rdy   <= (state_n != FULL);
    end
  end

  always_comb begin
    state_n = state;
    head_n  = head;
    skid_n  = skid;
    if (bus.flush) begin
      // Flush wins over any transfer; only a FULL stage keeps something when
      // the skid entry is preserved.
      if (FLUSH_KEEP_SKID && (state == FULL)) begin
        state_n = HALF;
        head_n  = skid;
        skid_n  = BUBBLE;
      end else begin
        state_n = EMPTY;
        head_n  = BUBBLE;
        skid_n  = BUBBLE;
      end
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_n = HALF;
            head_n  = bus.in_data;
          end
        end
        HALF: begin
          if (in_xfer && out_xfer) begin
            head_n = bus.in_data;
          end else if (in_xfer) begin
            state_n = FULL;
            skid_n  = bus.in_data;
          end else if (out_xfer) begin
            state_n = EMPTY;
            head_n  = BUBBLE;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_n = HALF;
            head_n  = skid;
            skid_n  = BUBBLE;
          end
        end
        default: begin
          state_n = EMPTY;
          head_n  = BUBBLE;
          skid_n  = BUBBLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: two instances (flush clears all / flush keeps skid)
// driven in lockstep, each checked against a payload-queue model.
module tb_pipe_skid_stage;
  localparam int W = 160;
  localparam logic [W-1:0] BUB1 = {5{32'hDEAD_BEEF}};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         flush = 1'b0;

  pipe_skid_stage_if #(.WIDTH(W)) b0 ();
  pipe_skid_stage_if #(.WIDTH(W)) b1 ();

  assign b0.in_valid  = in_valid;
  assign b0.in_data   = in_data;
  assign b0.out_ready = out_ready;
  assign b0.flush     = flush;
  assign b1.in_valid  = in_valid;
  assign b1.in_data   = in_data;
  assign b1.out_ready = out_ready;
  assign b1.flush     = flush;

  pipe_skid_stage #(.WIDTH(W), .FLUSH_KEEP_SKID(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave));
  pipe_skid_stage #(.WIDTH(W), .BUBBLE(BUB1), .FLUSH_KEEP_SKID(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave));

  logic [1:0]   ov, ir;
  logic [1:0]   occ_a [2];
  logic [W-1:0] od [2];
  assign ov[0] = b0.out_valid;  assign ov[1] = b1.out_valid;
  assign ir[0] = b0.in_ready;   assign ir[1] = b1.in_ready;
  assign occ_a[0] = b0.occ;     assign occ_a[1] = b1.occ;
  assign od[0] = b0.out_data;   assign od[1] = b1.out_data;

  int checks = 0;
  int errors = 0;

  // Model: ordered list of payloads held by each stage, oldest first
  logic [W-1:0] expq [2][$];
  bit           issued [2];
  logic [W-1:0] bub [2];

  task automatic chk(input string name, input int k, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issue one cycle of stimulus; payloads the stage will accept are queued
  task automatic cyc(input bit iv, input logic [W-1:0] d, input bit ordy,
                     input bit fl);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    for (int k = 0; k < 2; k++) begin
      if (iv && !fl && reset && (expq[k].size() < 2)) begin
        expq[k].push_back(d);
        issued[k] = 1'b1;
      end
    end
  endtask

  task automatic chk_reset_state(input string name);
    for (int k = 0; k < 2; k++) begin
      chk({name, "_occ"}, k, W'(occ_a[k]), '0);
      chk({name, "_out_valid"}, k, W'(ov[k]), '0);
      chk({name, "_in_ready"}, k, W'(ir[k]), W'(1));
      chk({name, "_out_data"}, k, od[k], bub[k]);
    end
  endtask

  // Monitor: samples just before each rising edge, compares, then retires
  initial begin
    int n;
    logic [W-1:0] hd;
    bit popped;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        for (int k = 0; k < 2; k++) begin
          n  = expq[k].size() - (issued[k] ? 1 : 0);
          hd = (n > 0) ? expq[k][0] : bub[k];
          chk("occ", k, W'(occ_a[k]), W'(n));
          chk("in_ready", k, W'(ir[k]), W'(n < 2));
          chk("out_valid", k, W'(ov[k]), W'(n > 0));
          chk("out_data", k, od[k], hd);
          popped = 1'b0;
          if (n > 0 && out_ready) begin
            hd = expq[k].pop_front();
            n--;
            popped = 1'b1;
          end
          if (flush) begin
            if (k == 0) expq[k].delete();
            else if (!popped && n > 0) hd = expq[k].pop_front();
          end
        end
      end
      issued[0] = 1'b0;
      issued[1] = 1'b0;
    end
  end

  initial begin
    logic [W-1:0] a, b;
    bub[0] = '0;
    bub[1] = BUB1;
    issued[0] = 1'b0;
    issued[1] = 1'b0;
    #1 reset = 1'b0;
    #1 chk_reset_state("por");
    @(negedge clk);
    #2 reset = 1'b1;

    // Streaming at full rate
    for (int i = 0; i < 4; i++) cyc(1'b1, rnd(), 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Stall to FULL, offered third payload refused, then drain
    a = rnd(); b = rnd();
    cyc(1'b1, a, 1'b0, 1'b0);
    cyc(1'b1, b, 1'b0, 1'b0);
    cyc(1'b1, rnd(), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Flush from FULL, stalled and with a simultaneous out-transfer
    for (int f = 0; f < 2; f++) begin
      cyc(1'b1, rnd(), 1'b0, 1'b0);
      cyc(1'b1, rnd(), 1'b0, 1'b0);
      cyc(1'b0, '0, f[0], 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end

    // Flush in HALF with a concurrent push: the push is dropped
    cyc(1'b1, rnd(), 1'b0, 1'b0);
    cyc(1'b1, rnd(), 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // FULL: in_ready must not follow a mid-cycle out_ready change
    cyc(1'b1, rnd(), 1'b0, 1'b0);
    cyc(1'b1, rnd(), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2 out_ready = 1'b1;
    #1 begin
      chk("in_ready_comb", 0, W'(ir[0]), '0);
      chk("in_ready_comb", 1, W'(ir[1]), '0);
    end

    // Asynchronous reset while FULL, then first push after release
    cyc(1'b1, rnd(), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset_state("async_reset");
    expq[0].delete();
    expq[1].delete();
    @(negedge clk);
    #2 reset = 1'b1;
    cyc(1'b1, rnd(), 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 10000; i++) begin
      int bias;
      bias = (i / 500) % 4;
      cyc($urandom_range(0, 3) != 0, rnd(),
          $urandom_range(0, 3) < bias + 1, $urandom_range(0, 40) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drained", 0, W'(expq[0].size()), '0);
    chk("drained", 1, W'(expq[1].size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter WIDTH, default 160, SHALL set the payload width in bits (for example five 32-bit pipeline fields).
REQ-002 Parameter BUBBLE, default {WIDTH{1'b0}}, SHALL set the payload value driven when the stage holds no valid entry (an all-zero IR is a NOP).
REQ-003 Parameter FLUSH_KEEP_SKID, default 0, SHALL select flush behaviour: 0 = clear both entries; 1 = clear only the head entry.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL indicate that the upstream stage presents a payload.
REQ-007 in_ready  output  1  SHALL indicate that the stage can accept a payload this cycle.
REQ-008 in_data  input  WIDTH  SHALL carry the upstream payload.
REQ-009 out_valid  output  1  SHALL indicate that the head entry is valid.
REQ-010 out_ready  input  1  SHALL indicate that the downstream stage consumes the head this cycle.
REQ-011 out_data  output  WIDTH  SHALL carry the head payload, or BUBBLE when out_valid=0.
REQ-012 flush  input  1  SHALL request synchronous squash of stage contents (branch or exception kill).
REQ-013 occ  output  2  SHALL report the entry count: 0, 1 or 2.

Function
REQ-014 The stage SHALL be a two-entry skid buffer with registers HEAD and SKID and states EMPTY (occ=0), HALF (occ=1, HEAD valid) and FULL (occ=2).
REQ-015 in_ready SHALL be driven directly from a flop: 1 in EMPTY and HALF, 0 in FULL, with no combinational path from out_ready.
REQ-016 A transfer in occurs when in_valid&in_ready at a clock edge; a transfer out occurs when out_valid&out_ready at a clock edge.
REQ-017 EMPTY: an in-transfer SHALL load HEAD and move to HALF; otherwise the state SHALL hold.
REQ-018 HALF: in-transfer only -> load SKID and move to FULL; out-transfer only -> move to EMPTY; both in-transfer and out-transfer -> load HEAD with in_data and stay in HALF; neither -> hold.
REQ-019 FULL: an out-transfer SHALL move SKID to HEAD and go to HALF; otherwise the state SHALL hold; no in-transfer is possible in FULL.
REQ-020 Latency SHALL be exactly one cycle from in-transfer to out_valid when the stage is EMPTY, and payload order SHALL be strict FIFO.
REQ-021 out_data SHALL be the HEAD register output (registered, not muxed from in_data), and SHALL equal BUBBLE whenever out_valid=0.
REQ-022 flush=1 with FLUSH_KEEP_SKID=0 SHALL force EMPTY at the next edge, and HEAD and SKID SHALL load BUBBLE.
REQ-023 flush=1 with FLUSH_KEEP_SKID=1 SHALL discard HEAD; a valid SKID SHALL move to HEAD (FULL->HALF, HALF->EMPTY).
REQ-024 flush SHALL override simultaneous in-transfers and out-transfers: an in_data accepted in a flush cycle SHALL be dropped, and an out-transfer in that cycle still counts as consumed downstream.
REQ-025 occ SHALL never exceed 2, and in_ready=0 SHALL coincide exactly with occ=2.
REQ-026 An unchanged payload SHALL hold its value while out_valid=1 and out_ready=0 (stall), with no bubble insertion.

Reset
REQ-027 reset=0 SHALL immediately, without a clock edge, force EMPTY, out_valid=0, out_data=BUBBLE, occ=0, in_ready=1 and SKID=BUBBLE.
REQ-028 Reset asserted mid-operation SHALL discard all held entries, and no transfer SHALL be reported on the deasserting edge.
REQ-029 After reset deassertion, the first rising edge SHALL be a normal operating edge.

Verification
REQ-030 Scenario: after reset, drive in_valid=1, in_data=A, out_ready=1 on every cycle for 4 cycles -> out_valid from cycle 1, out_data sequence A0..A3 one cycle late, occ=1 steady, in_ready=1 throughout.
REQ-031 Scenario: with out_ready=0, push A then B -> occ=2, in_ready=0, out_data=A held; then out_ready=1 for 2 cycles -> A then B delivered, occ 2->1->0.
REQ-032 Scenario: FULL with A/B, flush=1 for one cycle with FLUSH_KEEP_SKID=0 -> next cycle occ=0, out_valid=0, out_data=BUBBLE (0x0); with FLUSH_KEEP_SKID=1 -> occ=1, out_data=B.
REQ-033 Scenario: HALF with A, in_valid=1 with C and flush=1 in the same cycle -> C dropped, occ=0 (FLUSH_KEEP_SKID=0).
REQ-034 Scenario: FULL, assert reset=0 between clock edges -> outputs reach their reset values before the next edge; release reset -> first push of D gives out_data=D one cycle later.
REQ-035 Scenario: random in_valid/out_ready for 10k cycles with a scoreboard -> no loss, duplication or reorder; in_ready never depends combinationally on out_ready.
